// File: rtl/ctrl_pkt_arbiter.sv
// ctrl_pkt_arbiter: shares one outbound control-packet AXI-Stream channel among
// N sources. Grants are packet-atomic and round-robin, with a high-priority
// class that wins whenever any of its members is eligible. A watchdog ends a
// packet whose granted source goes idle mid-packet: it sends a zero-keep
// terminator beat and then silently drains the rest of that source's packet.
module ctrl_pkt_arbiter #(
  parameter int           N            = 4,
  parameter logic [N-1:0] HI_PRIO_MASK = N'(1),
  parameter int           TIMEOUT      = 1024
) (
  input  logic            core_clk,
  input  logic            core_rst_n,
  input  logic [64*N-1:0] s_tdata,
  input  logic [8*N-1:0]  s_tkeep,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [63:0]     m_tdata,
  output logic [7:0]      m_tkeep,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic            abort_o,
  output logic [31:0]     pkt_cnt_o
);

  localparam int          IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_ABORT
  } state_e;

  state_e             state_q,   state_d;
  logic [N-1:0]       grant_q,   grant_d;
  logic [IDX_W-1:0]   gidx_q,    gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [N-1:0]       flush_q,   flush_d;
  logic [15:0]        wdog_q,    wdog_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d;
  logic               busy_q,    busy_d;

  // Arbitration results and the granted source's view of the stream.
  logic [N-1:0]       elig;
  logic [N-1:0]       hi_elig;
  logic [N-1:0]       cand;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   nxt_ptr;
  logic               g_valid;
  logic               g_last;
  logic [63:0]        g_data;
  logic [7:0]         g_keep;

  assign g_valid = s_tvalid[gidx_q];
  assign g_last  = s_tlast[gidx_q];
  assign g_data  = s_tdata[gidx_q*64 +: 64];
  assign g_keep  = s_tkeep[gidx_q*8 +: 8];
  assign nxt_ptr = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + IDX_W'(1);

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign pkt_cnt_o = pkt_cnt_q;

  // Round-robin pick: high-priority class first, then first set bit at or
  // above rr_ptr, wrapping. Flushing sources are never eligible.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    elig       = s_tvalid & ~flush_q;
    hi_elig    = elig & HI_PRIO_MASK;
    cand       = (|hi_elig) ? hi_elig : elig;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && cand[(int'(rr_ptr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr_q) + k) % N);
      end
    end
  end

  // Output datapath: pass-through in XFER, terminator in ABORT, quiet in IDLE.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    abort_o  = 1'b0;
    s_tready = flush_q;
    case (state_q)
      ST_XFER: begin
        m_tvalid         = g_valid;
        m_tlast          = g_last;
        m_tdata          = g_data;
        m_tkeep          = g_keep;
        s_tready[gidx_q] = m_tready;
      end
      ST_ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        abort_o  = m_tready;
      end
      default: ;
    endcase
  end

  // Next-state logic: FSM, watchdog, flush bookkeeping and packet counter.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    wdog_d    = wdog_q;
    pkt_cnt_d = pkt_cnt_q;
    busy_d    = busy_q;
    flush_d   = flush_q;

    // A flushing source drops out of flush once its tlast beat is swallowed.
    for (int i = 0; i < N; i++) begin
      if (flush_q[i] && s_tvalid[i] && s_tlast[i]) flush_d[i] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_XFER;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
          wdog_d            = '0;
        end
      end
      ST_XFER: begin
        if (g_valid) begin
          // Backpressure never feeds the watchdog; only source silence does.
          wdog_d = '0;
          if (m_tready && g_last) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            rr_ptr_d  = nxt_ptr;
            grant_d   = '0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (wdog_q == WDOG_MAX) begin
          flush_d[gidx_q] = 1'b1;
          wdog_d          = '0;
          state_d         = ST_ABORT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_ABORT: begin
        if (m_tready) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          rr_ptr_d  = nxt_ptr;
          grant_d   = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any packet in flight without a terminator.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      flush_q   <= '0;
      wdog_q    <= '0;
      pkt_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      flush_q   <= flush_d;
      wdog_q    <= wdog_d;
      pkt_cnt_q <= pkt_cnt_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// tb_ctrl_pkt_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter kept in the bench.
module tb_ctrl_pkt_arbiter;

  localparam int           N  = 4;
  localparam int           TO = 8;
  localparam int           D  = 64;
  localparam logic [N-1:0] HI = 4'b0001;

  logic            core_clk = 1'b0;
  logic            core_rst_n;
  logic [64*N-1:0] s_tdata;
  logic [8*N-1:0]  s_tkeep;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            abort_o;
  logic [31:0]     pkt_cnt_o;

  ctrl_pkt_arbiter #(.N(N), .HI_PRIO_MASK(HI), .TIMEOUT(TO)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_o(grant_o), .busy_o(busy_o), .abort_o(abort_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_abort  = 0;

  // Per-source beat rings: gap = idle cycles before the beat is offered.
  int          bgap  [N][D];
  logic        blast [N][D];
  logic [63:0] bdata [N][D];
  logic [7:0]  bkeep [N][D];
  int          head  [N];
  int          tail  [N];
  logic        drv_valid [N];
  logic        drv_last  [N];
  logic [63:0] drv_data  [N];
  logic [7:0]  drv_keep  [N];

  // Reference model: owner=-1 when nobody holds the channel.
  int          md_owner;
  bit          md_term;
  int          md_gap;
  int          md_rr;
  bit          md_flush [N];
  logic [31:0] md_pkts;

  logic [N-1:0] e_ready;
  logic [N-1:0] e_grant;
  logic         e_valid, e_last, e_abort;
  logic [63:0]  e_data;
  logic [7:0]   e_keep;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int src, input int gap, input logic last);
    int t;
    t = tail[src] % D;
    bgap[src][t]  = gap;
    blast[src][t] = last;
    bdata[src][t] = {8'(src), 24'(tail[src]), 32'($urandom)};
    bkeep[src][t] = 8'($urandom_range(1, 255));
    tail[src]++;
  endtask

  task automatic push_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) push_beat(src, 0, b == len - 1);
  endtask

  task automatic model_reset();
    md_owner = -1;
    md_term  = 0;
    md_gap   = 0;
    md_rr    = 0;
    md_pkts  = '0;
    for (int i = 0; i < N; i++) begin
      md_flush[i]  = 0;
      head[i]      = 0;
      tail[i]      = 0;
      drv_valid[i] = 0;
      drv_last[i]  = 0;
      drv_data[i]  = '0;
      drv_keep[i]  = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!drv_valid[i] && head[i] != tail[i]) begin
        int h;
        h = head[i] % D;
        if (bgap[i][h] > 0) bgap[i][h] = bgap[i][h] - 1;
        else begin
          drv_valid[i] = 1;
          drv_last[i]  = blast[i][h];
          drv_data[i]  = bdata[i][h];
          drv_keep[i]  = bkeep[i][h];
        end
      end
      s_tvalid[i]       = drv_valid[i];
      s_tlast[i]        = drv_valid[i] & drv_last[i];
      s_tdata[i*64+:64] = drv_data[i];
      s_tkeep[i*8+:8]   = drv_keep[i];
    end
  endtask

  task automatic finish_pkt();
    md_pkts  = md_pkts + 32'd1;
    md_rr    = (md_owner + 1) % N;
    md_owner = -1;
    md_term  = 0;
  endtask

  // One clock of the model, using the inputs the DUT sees at this edge.
  task automatic model_advance();
    bit nf [N];
    bit any_hi;
    for (int i = 0; i < N; i++) nf[i] = md_flush[i] && !(drv_valid[i] && drv_last[i]);
    if (md_owner < 0) begin
      any_hi = 0;
      for (int i = 0; i < N; i++) if (drv_valid[i] && !md_flush[i] && HI[i]) any_hi = 1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (md_rr + k) % N;
        if (md_owner < 0 && drv_valid[i] && !md_flush[i] && (!any_hi || HI[i])) begin
          md_owner = i;
          md_gap   = 0;
        end
      end
    end else if (md_term) begin
      if (m_tready) finish_pkt();
    end else if (drv_valid[md_owner]) begin
      md_gap = 0;
      if (m_tready && drv_last[md_owner]) finish_pkt();
    end else begin
      md_gap++;
      if (md_gap == TO) begin
        md_term      = 1;
        nf[md_owner] = 1;
        md_gap       = 0;
      end
    end
    for (int i = 0; i < N; i++) md_flush[i] = nf[i];
  endtask

  // Drive, settle, and compare every DUT output with the model.
  task automatic sample();
    drive();
    #1;
    e_grant = '0;
    e_valid = 0; e_last = 0; e_data = '0; e_keep = '0; e_abort = 0;
    for (int i = 0; i < N; i++) e_ready[i] = md_flush[i];
    if (md_owner >= 0) begin
      e_grant[md_owner] = 1'b1;
      if (md_term) begin
        e_valid = 1; e_last = 1; e_abort = m_tready;
      end else begin
        e_valid           = drv_valid[md_owner];
        e_last            = drv_last[md_owner];
        e_data            = drv_data[md_owner];
        e_keep            = drv_keep[md_owner];
        e_ready[md_owner] = m_tready;
      end
    end
    check("m_tvalid", 64'(m_tvalid), 64'(e_valid));
    if (e_valid) begin
      check("m_tlast", 64'(m_tlast), 64'(e_last));
      check("m_tdata", m_tdata, e_data);
      check("m_tkeep", 64'(m_tkeep), 64'(e_keep));
    end
    check("s_tready", 64'(s_tready), 64'(e_ready));
    check("grant_o", 64'(grant_o), 64'(e_grant));
    check("busy_o", 64'(busy_o), 64'(md_owner >= 0));
    check("abort_o", 64'(abort_o), 64'(e_abort));
    check("pkt_cnt_o", 64'(pkt_cnt_o), 64'(md_pkts));
    if (abort_o) n_abort++;
  endtask

  task automatic advance();
    @(posedge core_clk);
    model_advance();
    for (int i = 0; i < N; i++) begin
      if (drv_valid[i] && e_ready[i]) begin
        head[i]++;
        drv_valid[i] = 0;
        drv_last[i]  = 0;
      end
    end
    @(negedge core_clk);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset();
    core_rst_n = 1'b0;
    m_tready   = 1'b1;
    model_reset();
    drive();
    @(posedge core_clk);
    @(posedge core_clk);
    @(negedge core_clk);
    core_rst_n = 1'b1;
  endtask

  int base_pkts;
  int base_abort;

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
    do_reset();

    // Reset state.
    sample();
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_mvalid", 64'(m_tvalid), 64'(0));
    check("rst_sready", 64'(s_tready), 64'(0));
    check("rst_pkts", 64'(pkt_cnt_o), 64'(0));
    advance();

    // Single 3-beat packet from low-priority source 1.
    push_pkt(1, 3);
    for (int c = 0; c < 5; c++) begin
      sample();
      case (c)
        0: check("t1_grant_before", 64'(grant_o), 64'(0));
        1: begin
          check("t1_grant", 64'(grant_o), 64'(4'b0010));
          check("t1_beat1_valid", 64'(m_tvalid), 64'(1));
        end
        2: check("t1_beat2_last", 64'(m_tlast), 64'(0));
        3: check("t1_beat3_last", 64'(m_tlast), 64'(1));
        4: begin
          check("t1_grant_after", 64'(grant_o), 64'(0));
          check("t1_pkts", 64'(pkt_cnt_o), 64'(1));
          check("t1_model_pkts", 64'(md_pkts), 64'(1));
        end
        default: ;
      endcase
      advance();
    end

    // Round-robin among 1,2,3 with a bubble between packets.
    do_reset();
    for (int s = 1; s < 4; s++) begin
      push_pkt(s, 1);
      push_pkt(s, 1);
    end
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] eg;
      sample();
      eg = '0;
      if (c % 2 == 1) eg = N'(1) << (1 + ((c - 1) / 2) % 3);
      check("t2_rr_grant", 64'(grant_o), 64'(eg));
      advance();
    end
    check("t2_pkts", 64'(pkt_cnt_o), 64'(6));

    // High-priority source 0 beats source 2 even with rr_ptr=1.
    do_reset();
    push_pkt(0, 1);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        check("t3_model_rr", 64'(md_rr), 64'(1));
        push_pkt(0, 1);
        push_pkt(2, 1);
      end
      sample();
      if (c == 3) check("t3_hi_first", 64'(grant_o), 64'(4'b0001));
      if (c == 5) check("t3_then_src2", 64'(grant_o), 64'(4'b0100));
      advance();
    end

    // Long backpressure with tvalid held: no abort, packet completes.
    base_pkts  = int'(pkt_cnt_o);
    base_abort = n_abort;
    push_pkt(1, 2);
    m_tready = 1'b0;
    run(5001);
    check("t4_stalled_busy", 64'(busy_o), 64'(1));
    m_tready = 1'b1;
    run(4);
    check("t4_no_abort", 64'(n_abort - base_abort), 64'(0));
    check("t4_pkt_done", 64'(int'(pkt_cnt_o) - base_pkts), 64'(1));

    // Watchdog abort after TO idle cycles, then drain of the remainder.
    base_pkts = int'(pkt_cnt_o);
    push_beat(1, 0, 1'b0);
    push_beat(1, 10, 1'b0);
    push_beat(1, 0, 1'b1);
    for (int c = 0; c < 15; c++) begin
      sample();
      case (c)
        9: check("t5_no_early_abort", 64'(abort_o), 64'(0));
        10: begin
          check("t5_term_valid", 64'(m_tvalid), 64'(1));
          check("t5_term_last", 64'(m_tlast), 64'(1));
          check("t5_term_keep", 64'(m_tkeep), 64'(0));
          check("t5_term_data", m_tdata, 64'(0));
          check("t5_abort_pulse", 64'(abort_o), 64'(1));
        end
        12, 13: begin
          check("t5_drain_mvalid", 64'(m_tvalid), 64'(0));
          check("t5_drain_ready", 64'(s_tready[1]), 64'(1));
        end
        14: begin
          check("t5_flush_clear", 64'(s_tready[1]), 64'(0));
          check("t5_pkts", 64'(int'(pkt_cnt_o) - base_pkts), 64'(1));
        end
        default: ;
      endcase
      advance();
    end

    // Reset mid-XFER, then arbitration restarts from rr_ptr=0.
    do_reset();
    push_pkt(2, 1);
    run(2);
    push_pkt(3, 2);
    sample();
    advance();
    sample();
    check("t6_in_xfer", 64'(grant_o), 64'(4'b1000));
    core_rst_n = 1'b0;
    #1;
    check("t6_rst_mvalid", 64'(m_tvalid), 64'(0));
    check("t6_rst_grant", 64'(grant_o), 64'(0));
    check("t6_rst_busy", 64'(busy_o), 64'(0));
    check("t6_rst_pkts", 64'(pkt_cnt_o), 64'(0));
    check("t6_rst_sready", 64'(s_tready), 64'(0));
    model_reset();
    drive();
    @(posedge core_clk);
    @(negedge core_clk);
    core_rst_n = 1'b1;
    push_pkt(1, 1);
    push_pkt(3, 1);
    run(1);
    sample();
    check("t6_rr_restart", 64'(grant_o), 64'(4'b0010));
    check("t6_pkts_zero", 64'(pkt_cnt_o), 64'(0));
    advance();

    // Randomized traffic with occasional long source gaps and backpressure.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int s = 0; s < N; s++) begin
        if (tail[s] - head[s] < 4) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            int g;
            g = ($urandom_range(0, 19) < 2) ? $urandom_range(9, 12) : $urandom_range(0, 3);
            push_beat(s, g, b == len - 1);
          end
        end
      end
      m_tready = ($urandom_range(0, 9) < 8);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pkt_arbiter.md
Name: ctrl_pkt_arbiter

Overview:
- Shares one outbound control-packet AXI-Stream channel (64-bit data, 8-bit keep) among N control sources: handshake request, close, ACK, NAK and keep-alive.
- Sits between the connection-management blocks and the packet encapsulator.
- Grants are packet-atomic and round-robin, with a high-priority class.
- A watchdog aborts packets whose granted source stalls mid-packet and flushes the rest of that packet.

Parameters:
- N, 4, number of source ports (2..8).
- HI_PRIO_MASK, 4'b0001, bit i=1 puts source i in the high-priority class.
- TIMEOUT, 1024, idle cycles mid-packet (s_tvalid low) before abort; 1..2^16-1.

Ports:
- core_clk  in  1  core clock; all logic on rising edge.
- core_rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  64*N  source data, source i at [64i+63:64i].
- s_tkeep  in  8*N  source byte enables.
- s_tvalid  in  N  source valid.
- s_tlast  in  N  source end of packet.
- s_tready  out  N  source ready.
- m_tdata  out  64  merged data.
- m_tkeep  out  8  merged keep.
- m_tvalid  out  1  merged valid.
- m_tlast  out  1  merged last.
- m_tready  in  1  downstream ready.
- grant_o  out  N  one-hot current grant; 0 when idle.
- busy_o  out  1  high in XFER or ABORT.
- abort_o  out  1  one-cycle pulse when the terminator beat is accepted.
- pkt_cnt_o  out  32  completed packets, including aborted ones; wraps at 2^32.

Behaviour:
- Reset values:
  - state=IDLE, grant_o=0, rr_ptr=0, flush=0, wdog=0.
  - m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0.
  - s_tready=0, busy_o=0, abort_o=0, pkt_cnt_o=0.
  - Reset mid-packet abandons the packet with no terminator.
- Eligible set E = s_tvalid & ~flush.
- IDLE:
  - If E has any high-priority bit, pick from those; else pick from all of E.
  - Selection is the first set bit at or above rr_ptr, circularly.
  - Register grant and go to XFER. Grant latency is 1 cycle; no beat transfers in IDLE.
  - m_tvalid=0 in IDLE.
- XFER (granted source g):
  - m_* = s_*[g] combinationally.
  - s_tready[g] = m_tready; other sources' s_tready = flush[i].
  - A beat transfers when s_tvalid[g] & m_tready.
  - On a transferred beat with s_tlast[g]: pkt_cnt_o++, rr_ptr = (g+1) mod N, grant_o=0, go to IDLE.
  - A new packet, even from the same source, needs another IDLE cycle, so back-to-back packets leave 1 bubble.
- Watchdog (XFER only):
  - wdog increments each cycle s_tvalid[g]=0.
  - Clears on any cycle s_tvalid[g]=1; backpressure from m_tready does not count.
  - When wdog reaches TIMEOUT-1 with s_tvalid[g] still 0: set flush[g], go to ABORT.
- ABORT:
  - Drive terminator beat: m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0; s_tready[g]=flush[g]=1.
  - On m_tready: abort_o pulses that cycle, pkt_cnt_o++, rr_ptr=(g+1) mod N, go to IDLE.
- Flush:
  - While flush[i]=1: s_tready[i]=1, beats discarded, source excluded from arbitration.
  - flush[i] clears on the cycle a beat with s_tlast[i]=1 is consumed.
  - If the source's tlast arrives during ABORT, the flush clears the same cycle.
- Simultaneous events: flush clear and eligibility are evaluated with registered flush, so a flushed source is eligible at the earliest the cycle after its tlast.
- Source-side violations (dropping valid mid-beat) are not detected; only the idle-gap watchdog applies.
- grant_o and busy_o are registered state outputs.

Test Plan:
- Single source 1 (lo-prio) sends a 3-beat packet, m_tready=1 → grant_o=0010 one cycle after s_tvalid rises; 3 beats out, m_tlast on beat 3; pkt_cnt_o=1; grant_o=0 next cycle.
- Sources 1, 2, 3 each continuously send 1-beat packets, none high-priority → grant order 1,2,3,1,2,3; each packet separated by 1 idle cycle; pkt_cnt_o=6 after 12 cycles.
- Source 0 (hi-prio) and source 2 both valid, rr_ptr=1 → source 0 granted first, then source 2.
- m_tready low for 5000 cycles mid-packet while the source holds tvalid → no abort; transfer completes once m_tready returns.
- TIMEOUT=8: source 1 sends beat 1, drops tvalid for 8 cycles → terminator beat (tkeep=0, tlast=1) out; abort_o pulses; then source 1's remaining 2 beats are absorbed with m_tvalid=0; flush clears on its tlast.
- core_rst_n asserted mid-XFER → all outputs zero immediately; after release, pkt_cnt_o=0 and the next packet is arbitrated from rr_ptr=0.
